load_store_memory: RTL and testbench

LOAD_STORE_MEMORY -- requirements
Module: LoadStoreMemory

---
 rtl/load_store_memory_pkg.sv | 42 ++++
 rtl/load_store_memory_response_fifo.sv | 51 +++++
 rtl/load_store_memory.sv | 125 ++++++++++++
 tb/tb_load_store_memory.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_memory_pkg.sv
// Shared types and helpers for the load/store memory block:
// access sizes, fault detection and load-data extension.
package load_store_memory_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } size_e;

  function automatic logic is_fault(
    input logic [1:0]  size,
    input logic [31:0] addr,
    input int unsigned cap,
    input int unsigned bw
  );
    logic [31:0] mask;
    logic [32:0] last;
    mask = (32'd1 << size) - 32'd1;
    last = {1'b0, addr} + (33'd1 << size);
    return ((addr & mask) != 32'd0)
        || (last > 33'(cap))
        || ((size_e'(size) == SZ_DOUBLE) && (bw == 32));
  endfunction

  function automatic logic [63:0] extend(
    input logic [63:0] raw,
    input logic [1:0]  size,
    input logic        sign
  );
    logic [63:0] res;
    case (size_e'(size))
      SZ_BYTE: res = {{56{sign & raw[7]}}, raw[7:0]};
      SZ_HALF: res = {{48{sign & raw[15]}}, raw[15:0]};
      SZ_WORD: res = {{32{sign & raw[31]}}, raw[31:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/load_store_memory_response_fifo.sv
// In-order response buffer for completed loads.
// Overflow is prevented upstream by the credit counter.
module load_store_memory_response_fifo #(
  parameter int Width = 33,
  parameter int Depth = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] dout,
  output logic             empty
);

  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem [Depth];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [PW:0]      cnt;
  logic             do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty  = (cnt == '0);
  assign do_pop = pop & ~empty;
  assign dout   = mem[rp];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= nxt(wp);
      end
      if (do_pop) rp <= nxt(rp);
      unique case ({push, do_pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/load_store_memory.sv
// Byte-addressed load/store memory with fixed read latency,
// credit-based load flow control and an in-order response buffer.
module load_store_memory
  import load_store_memory_pkg::*;
#(
  parameter int BitWidth    = 32,
  parameter int Capacity    = 1024,
  parameter int ReadLatency = 2,
  parameter int RespDepth   = ReadLatency + 1,
  localparam int AddrWidth  = $clog2(Capacity)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic                 write,
  input  logic [1:0]           size,
  input  logic                 signExt,
  input  logic [AddrWidth-1:0] addr,
  input  logic [BitWidth-1:0]  wData,
  output logic                 rValid,
  input  logic                 rReady,
  output logic [BitWidth-1:0]  rData,
  output logic                 rError,
  output logic                 wError
);

  localparam int NB = BitWidth / 8;
  localparam int CW = $clog2(RespDepth + 1);

  logic [7:0]          mem [Capacity];
  logic [CW-1:0]       used;
  logic                accept;
  logic                ld_acc;
  logic                st_acc;
  logic                fault;
  logic                pop;
  logic                empty;
  logic                werr_q;
  logic [3:0]          nbytes;
  logic [63:0]         raw;
  logic [BitWidth-1:0] ld_data;
  logic [BitWidth:0]   head;
  logic [ReadLatency-1:0] pv;
  logic [BitWidth:0]   pd [ReadLatency];

  assign fault  = is_fault(size, 32'(addr), Capacity, BitWidth);
  assign nbytes = 4'd1 << size;

  // Stores bypass the credit check; only loads consume buffer space.
  assign reqReady = reset
                  & ((used < CW'(RespDepth)) | (reqValid & write));
  assign accept   = enable & reqValid & reqReady;
  assign ld_acc   = accept & ~write;
  assign st_acc   = accept & write;

  assign rValid = reset & ~empty;
  assign pop    = rValid & rReady;
  assign rData  = rValid ? head[BitWidth-1:0] : '0;
  assign rError = rValid & head[BitWidth];
  assign wError = reset & werr_q;

  always_comb begin
    raw = '0;
    for (int k = 0; k < NB; k++)
      raw[8*k +: 8] = mem[addr + AddrWidth'(k)];
    ld_data = fault ? '0
            : BitWidth'(extend(raw, size, signExt));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      pv <= '0;
    end else begin
      pv[0] <= ld_acc;
      pd[0] <= {fault, ld_data};
      for (int i = 1; i < ReadLatency; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      used <= '0;
    end else begin
      unique case ({ld_acc, pop})
        2'b10:   used <= used + CW'(1);
        2'b01:   used <= used - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < Capacity; i++)
        mem[i] <= '0;
      werr_q <= 1'b0;
    end else begin
      werr_q <= st_acc & fault;
      if (st_acc & ~fault) begin
        for (int k = 0; k < NB; k++)
          if (4'(k) < nbytes)
            mem[addr + AddrWidth'(k)] <= wData[8*k +: 8];
      end
    end
  end

  load_store_memory_response_fifo #(
    .Width (BitWidth + 1),
    .Depth (RespDepth)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (pv[ReadLatency-1]),
    .din   (pd[ReadLatency-1]),
    .pop   (pop),
    .dout  (head),
    .empty (empty)
  );

endmodule

// File: tb/tb_load_store_memory.sv
// Bench for load_store_memory: directed scenarios plus random
// traffic against a byte-array / response-queue reference model.
module tb_load_store_memory;

  localparam int BW  = 32;
  localparam int CAP = 1024;
  localparam int RL  = 2;
  localparam int RD  = 3;
  localparam int AW  = 10;

  logic          clock = 0;
  logic          reset = 0;
  logic          enable = 0;
  logic          reqValid = 0;
  logic          write = 0;
  logic          signExt = 0;
  logic          rReady = 0;
  logic [1:0]    size = 0;
  logic [AW-1:0] addr = 0;
  logic [BW-1:0] wData = 0;
  logic          reqReady;
  logic          rValid;
  logic          rError;
  logic          wError;
  logic [BW-1:0] rData;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [BW-1:0] data;
    logic          err;
    int            due;
  } resp_t;

  byte unsigned mm [CAP];
  resp_t        q [$];
  int           now = 0;
  bit           m_werr = 0;
  bit           dut_acc;

  always #5 clock = ~clock;

  load_store_memory #(
    .BitWidth    (BW),
    .Capacity    (CAP),
    .ReadLatency (RL),
    .RespDepth   (RD)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .enable   (enable),
    .reqValid (reqValid),
    .reqReady (reqReady),
    .write    (write),
    .size     (size),
    .signExt  (signExt),
    .addr     (addr),
    .wData    (wData),
    .rValid   (rValid),
    .rReady   (rReady),
    .rData    (rData),
    .rError   (rError),
    .wError   (wError)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] m_load(int sz, int a, bit sx);
    longint unsigned v = 0;
    int n = 1 << sz;
    for (int k = 0; k < n; k++)
      v |= longint'(mm[a+k]) << (8*k);
    if (sx && ((v >> (8*n-1)) & 1) == 1)
      v -= (longint'(1) << (8*n));
    return BW'(v);
  endfunction

  // One clock: check outputs at the falling edge, then apply the
  // rising-edge effect of the current inputs to the model.
  task automatic tick();
    bit er, rv, f;
    int a, sz, n;
    resp_t r;
    @(negedge clock);
    er = reset && (q.size() < RD || (reqValid && write));
    rv = reset && q.size() > 0 && q[0].due <= now;
    check("reqReady", reqReady, er);
    check("rValid", rValid, rv);
    check("rData", rData, rv ? 64'(q[0].data) : 64'd0);
    check("rError", rError, rv ? q[0].err : 1'b0);
    check("wError", wError, reset && m_werr);
    dut_acc = reset && enable && reqValid && reqReady;
    a  = int'(addr);
    sz = int'(size);
    n  = 1 << sz;
    f  = (a % n != 0) || (a + n > CAP) || (sz == 3 && BW == 32);
    if (!reset) begin
      foreach (mm[i]) mm[i] = 0;
      q.delete();
      m_werr = 0;
    end else begin
      m_werr = 0;
      if (rv && rReady) q.delete(0);
      if (enable && reqValid && er) begin
        if (!write) begin
          r.data = f ? '0 : m_load(sz, a, signExt);
          r.err  = f;
          r.due  = now + 1 + RL;
          q.push_back(r);
        end else if (f) begin
          m_werr = 1;
        end else begin
          for (int k = 0; k < n; k++) mm[a+k] = wData[8*k +: 8];
        end
      end
    end
    @(posedge clock);
    now++;
    #1;
  endtask

  task automatic req(input bit w, input int sz, input int a,
                     input logic [31:0] d, input bit sx);
    enable   = 1;
    reqValid = 1;
    write    = w;
    size     = 2'(sz);
    addr     = AW'(a);
    wData    = d;
    signExt  = sx;
    tick();
  endtask

  task automatic idle(input int n);
    reqValid = 0;
    repeat (n) tick();
  endtask

  int cnt;
  logic [31:0] d;

  initial begin
    idle(2);
    reset  = 1;
    rReady = 1;
    idle(1);

    // store word, sign-extended byte load, fixed latency
    req(1, 2, 'h10, 32'h8899AABB, 0);
    req(0, 0, 'h11, 0, 1);
    check("lat_e1", rValid, 0);
    idle(1);
    check("lat_e2", rValid, 0);
    idle(1);
    check("lat_valid", rValid, 1);
    check("lat_data", rData, 32'hFFFFFFAA);
    check("lat_err", rError, 0);

    // misaligned load and store
    req(0, 1, 'h11, 0, 0);
    idle(2);
    check("mis_ld_err", rError, 1);
    check("mis_ld_data", rData, 0);
    req(1, 2, 'h12, 32'hDEADBEEF, 0);
    check("mis_st_werr", wError, 1);
    idle(1);
    check("mis_st_pulse", wError, 0);
    req(0, 2, 'h10, 0, 0);
    idle(2);
    check("mis_st_keep", rData, 32'h8899AABB);
    idle(3);

    // credit exhaustion, store bypass, one pop frees one credit
    rReady = 0;
    cnt = 0;
    repeat (5) begin
      req(0, 2, 'h10, 0, 0);
      cnt += int'(dut_acc);
    end
    check("credit_fill", cnt, 3);
    check("credit_block", reqReady, 0);
    req(1, 0, 'h20, 32'h5A, 0);
    check("store_bypass", dut_acc, 1);
    reqValid = 0;
    rReady = 1;
    tick();
    rReady = 0;
    cnt = 0;
    repeat (3) begin
      req(0, 2, 'h10, 0, 0);
      cnt += int'(dut_acc);
    end
    check("credit_one", cnt, 1);
    rReady = 1;
    idle(6);

    // store then load on consecutive edges
    d = $urandom;
    req(1, 2, 'h40, d, 0);
    req(0, 2, 'h40, 0, 0);
    idle(2);
    check("raw_fwd", rData, d);
    idle(3);

    // reset with loads in flight
    req(0, 2, 'h40, 0, 0);
    req(0, 2, 'h10, 0, 0);
    reqValid = 0;
    reset = 0;
    tick();
    reset = 1;
    repeat (4) begin
      idle(1);
      check("rst_novalid", rValid, 0);
    end
    rReady = 0;
    cnt = 0;
    repeat (4) begin
      req(0, 2, 'h10, 0, 0);
      cnt += int'(dut_acc);
    end
    check("rst_credits", cnt, 3);
    rReady = 1;
    idle(6);
    req(0, 2, 'h40, 0, 0);
    idle(2);
    check("rst_cleared", rData, 0);
    idle(3);

    // out-of-range word load
    req(0, 2, CAP - 2, 0, 0);
    idle(2);
    check("oor_err", rError, 1);
    check("oor_data", rData, 0);
    idle(3);

    // random traffic
    repeat (600) begin
      int a, sz;
      sz = $urandom_range(0, 3);
      a  = (($urandom % 4) == 0) ? CAP - 16 : 0;
      a += $urandom_range(0, 15);
      if (($urandom % 5) != 0) a &= ~((1 << sz) - 1);
      enable   = ($urandom % 8) != 0;
      reqValid = $urandom % 2;
      write    = $urandom % 2;
      size     = 2'(sz);
      addr     = AW'(a);
      wData    = $urandom;
      signExt  = $urandom % 2;
      rReady   = ($urandom % 4) != 0;
      reset    = ($urandom % 150) != 0;
      tick();
    end
    reset  = 1;
    rReady = 1;
    idle(8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
